// File: rtl/conf_bank_seq_pkg.sv
// Shared defaults and FSM encoding for the Morse timing configuration bank.
package conf_bank_seq_pkg;

    localparam int DEF_NUM_TIMES   = 4;
    localparam int DEF_BCD_DIGITS  = 6;
    localparam int DEF_BIN_W       = 20;
    localparam int DEF_PULSE_CNT_W = 32;
    localparam int DEF_IDX_W       = 3;

    // entry 0 (dit) in the LSBs, pulses-per-unit scale in the MSBs
    localparam logic [119:0] DEF_UNITS_FLAT = {24'h050000, 24'h000500, 24'h007000,
                                               24'h003000, 24'h001000};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCALE  = 3'd1,
        ST_CONV   = 3'd2,
        ST_MUL    = 3'd3,
        ST_COMMIT = 3'd4
    } seq_state_e;

endpackage

// File: rtl/conf_bank_seq_bcd_to_bin_serial.sv
// Digit-serial BCD to binary converter, MSD first: acc = acc*10 + digit.
// The start cycle consumes the first digit; done pulses once bin_out holds the result.
module bcd_to_bin_serial #(
    parameter int DIGITS = 6,
    parameter int BIN_W  = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  done
);
    localparam int CNT_W = $clog2(DIGITS + 1);

    logic [4*DIGITS-1:0] sr_q, sr_d;
    logic [BIN_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    always_comb begin
        sr_d   = sr_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start) begin
            acc_d  = BIN_W'(bcd_in[4*DIGITS-1 -: 4]);
            sr_d   = bcd_in << 4;
            cnt_d  = CNT_W'(DIGITS - 1);
            busy_d = (DIGITS > 1);
            done_d = (DIGITS == 1);
        end else if (busy_q) begin
            acc_d = (acc_q << 3) + (acc_q << 1) + BIN_W'(sr_q[4*DIGITS-1 -: 4]);
            sr_d  = sr_q << 4;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_q   <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (ce) begin
            sr_q   <= sr_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign bin_out = acc_q;
    assign done    = done_q;

endmodule

// File: rtl/conf_bank_seq.sv
// Morse timing configuration bank: BCD entries, sequential unit*scale recompute, atomic commit.
//   state  | meaning
//   IDLE   | waiting; starts scale conversion when a recompute is pending
//   SCALE  | converting the scale entry to binary
//   CONV   | converting unit entry idx to binary
//   MUL    | shift-add unit*scale, saturate into shadow[idx]
//   COMMIT | copy all shadow timings to times_flat, raise ready
module conf_bank_seq
    import conf_bank_seq_pkg::*;
#(
    parameter int NUM_TIMES   = DEF_NUM_TIMES,
    parameter int BCD_DIGITS  = DEF_BCD_DIGITS,
    parameter int BIN_W       = DEF_BIN_W,
    parameter int PULSE_CNT_W = DEF_PULSE_CNT_W,
    parameter int IDX_W       = DEF_IDX_W,
    parameter logic [(NUM_TIMES+1)*4*BCD_DIGITS-1:0] DEFAULTS =
        ((NUM_TIMES+1)*4*BCD_DIGITS)'(DEF_UNITS_FLAT)
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    ce,
    input  logic [IDX_W-1:0]                        sel_index,
    output logic [4*BCD_DIGITS-1:0]                 sel_value,
    input  logic [4*BCD_DIGITS-1:0]                 sel_new_value,
    input  logic                                    sel_set,
    output logic                                    sel_err,
    output logic [(NUM_TIMES+1)*4*BCD_DIGITS-1:0]   units_flat,
    output logic [NUM_TIMES*PULSE_CNT_W-1:0]        times_flat,
    output logic                                    ready
);
    localparam int UNIT_W = 4 * BCD_DIGITS;
    localparam int PROD_W = 2 * BIN_W;
    localparam int EXT_W  = (PULSE_CNT_W > PROD_W) ? PULSE_CNT_W : PROD_W;
    localparam int CNT_W  = $clog2(BIN_W + 1);
    localparam logic [EXT_W-1:0] SAT_LIM = EXT_W'({PULSE_CNT_W{1'b1}});

    seq_state_e                            state_q, state_d;
    logic                                  pending_q, pending_d;
    logic                                  ready_q, ready_d;
    logic                                  sel_err_q, sel_err_d;
    logic [NUM_TIMES:0][UNIT_W-1:0]        units_q, units_d;
    logic [NUM_TIMES-1:0][PULSE_CNT_W-1:0] shadow_q, shadow_d;
    logic [NUM_TIMES-1:0][PULSE_CNT_W-1:0] times_q, times_d;
    logic [BIN_W-1:0]                      scale_bin_q, scale_bin_d;
    logic [BIN_W-1:0]                      mplier_q, mplier_d;
    logic [PROD_W-1:0]                     mcand_q, mcand_d;
    logic [PROD_W-1:0]                     prod_q, prod_d;
    logic [CNT_W-1:0]                      cnt_q, cnt_d;
    logic [IDX_W-1:0]                      idx_q, idx_d;

    logic [PROD_W-1:0] prod_add;
    logic [EXT_W-1:0]  prod_ext;
    logic              bcd_ok, wr_ok;
    logic              conv_start, conv_done;
    logic [IDX_W-1:0]  conv_idx;
    logic [UNIT_W-1:0] conv_bcd;
    logic [BIN_W-1:0]  conv_bin;

    always_comb begin
        bcd_ok = 1'b1;
        for (int k = 0; k < BCD_DIGITS; k++) begin
            if (sel_new_value[4*k +: 4] > 4'd9) bcd_ok = 1'b0;
        end
    end

    assign wr_ok     = bcd_ok && (sel_index <= IDX_W'(NUM_TIMES));
    assign sel_value = (sel_index <= IDX_W'(NUM_TIMES)) ? units_q[sel_index] : '0;
    assign prod_add  = prod_q + (mplier_q[0] ? mcand_q : '0);
    assign prod_ext  = EXT_W'(prod_add);
    assign conv_bcd  = units_q[conv_idx];

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        ready_d     = ready_q;
        sel_err_d   = 1'b0;
        units_d     = units_q;
        shadow_d    = shadow_q;
        times_d     = times_q;
        scale_bin_d = scale_bin_q;
        mplier_d    = mplier_q;
        mcand_d     = mcand_q;
        prod_d      = prod_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        conv_start  = 1'b0;
        conv_idx    = '0;

        if (sel_set && !wr_ok) sel_err_d = 1'b1;

        // An accepted write restarts the pass; committed timings stay until the next COMMIT.
        if (sel_set && wr_ok) begin
            units_d[sel_index] = sel_new_value;
            ready_d            = 1'b0;
            pending_d          = 1'b1;
            state_d            = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pending_q) begin
                        conv_start = 1'b1;
                        conv_idx   = IDX_W'(NUM_TIMES);
                        pending_d  = 1'b0;
                        state_d    = ST_SCALE;
                    end
                end
                ST_SCALE: begin
                    if (conv_done) begin
                        scale_bin_d = conv_bin;
                        conv_start  = 1'b1;
                        idx_d       = '0;
                        state_d     = ST_CONV;
                    end
                end
                ST_CONV: begin
                    if (conv_done) begin
                        mcand_d  = PROD_W'(conv_bin);
                        mplier_d = scale_bin_q;
                        prod_d   = '0;
                        cnt_d    = CNT_W'(BIN_W - 1);
                        state_d  = ST_MUL;
                    end
                end
                ST_MUL: begin
                    prod_d   = prod_add;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    if (cnt_q == '0) begin
                        shadow_d[idx_q] = (prod_ext > SAT_LIM) ? '1 : prod_ext[PULSE_CNT_W-1:0];
                        if (idx_q == IDX_W'(NUM_TIMES - 1)) begin
                            state_d = ST_COMMIT;
                        end else begin
                            idx_d      = idx_q + 1'b1;
                            conv_start = 1'b1;
                            conv_idx   = idx_q + 1'b1;
                            state_d    = ST_CONV;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_COMMIT: begin
                    times_d = shadow_q;
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pending_q   <= 1'b1;
            ready_q     <= 1'b0;
            sel_err_q   <= 1'b0;
            units_q     <= DEFAULTS;
            shadow_q    <= '0;
            times_q     <= '0;
            scale_bin_q <= '0;
            mplier_q    <= '0;
            mcand_q     <= '0;
            prod_q      <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
        end else if (ce) begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            ready_q     <= ready_d;
            sel_err_q   <= sel_err_d;
            units_q     <= units_d;
            shadow_q    <= shadow_d;
            times_q     <= times_d;
            scale_bin_q <= scale_bin_d;
            mplier_q    <= mplier_d;
            mcand_q     <= mcand_d;
            prod_q      <= prod_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
        end
    end

    bcd_to_bin_serial #(
        .DIGITS (BCD_DIGITS),
        .BIN_W  (BIN_W)
    ) u_conv (
        .clk     (clk),
        .rst_n   (rst_n),
        .ce      (ce),
        .start   (conv_start),
        .bcd_in  (conv_bcd),
        .bin_out (conv_bin),
        .done    (conv_done)
    );

    assign sel_err    = sel_err_q;
    assign ready      = ready_q;
    assign units_flat = units_q;
    assign times_flat = times_q;

endmodule

// File: tb/tb_conf_bank_seq.sv
// Randomized bench for conf_bank_seq against a countdown/arithmetic reference model.
module tb_conf_bank_seq;
    localparam int N   = 4;
    localparam int D   = 6;
    localparam int BW  = 20;
    localparam int IW  = 3;
    localparam int LAT = D + N * (D + BW) + 2;

    logic          clk = 1'b0;
    logic          rst_n, ce, sel_set, sel_err, ready;
    logic [IW-1:0] sel_index;
    logic [23:0]   sel_value, sel_new_value;
    logic [119:0]  units_flat;
    logic [127:0]  times_flat;

    int n_vec = 0;
    int n_bad = 0;

    logic [23:0] m_units [0:N];
    logic [31:0] m_times [0:N-1];
    logic        m_ready, m_err;
    int          m_cd;

    conf_bank_seq dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ce            (ce),
        .sel_index     (sel_index),
        .sel_value     (sel_value),
        .sel_new_value (sel_new_value),
        .sel_set       (sel_set),
        .sel_err       (sel_err),
        .units_flat    (units_flat),
        .times_flat    (times_flat),
        .ready         (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic longint bcd_val(input logic [23:0] b);
        longint v = 0;
        for (int k = 5; k >= 0; k--) v = v * 10 + longint'(b[4*k +: 4]);
        return v;
    endfunction

    function automatic bit bcd_legal(input logic [23:0] b);
        for (int k = 0; k < 6; k++) if (b[4*k +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_units[0] = 24'h001000;
        m_units[1] = 24'h003000;
        m_units[2] = 24'h007000;
        m_units[3] = 24'h000500;
        m_units[4] = 24'h050000;
        for (int i = 0; i < N; i++) m_times[i] = '0;
        m_ready = 1'b0;
        m_err   = 1'b0;
        m_cd    = LAT;
    endtask

    task automatic model_commit();
        longint p;
        for (int i = 0; i < N; i++) begin
            p = bcd_val(m_units[i]) * bcd_val(m_units[N]);
            m_times[i] = (p > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : p[31:0];
        end
        m_ready = 1'b1;
    endtask

    task automatic model_edge();
        bit wr_ok;
        if (!rst_n) begin
            model_reset();
        end else if (ce) begin
            wr_ok = sel_set && (int'(sel_index) <= N) && bcd_legal(sel_new_value);
            m_err = sel_set && !wr_ok;
            if (wr_ok) begin
                m_units[sel_index] = sel_new_value;
                m_ready = 1'b0;
                m_cd    = LAT;
            end else if (m_cd > 0) begin
                m_cd--;
                if (m_cd == 0) model_commit();
            end
        end
    endtask

    task automatic compare_all();
        logic [127:0] et;
        logic [119:0] eu;
        logic [23:0]  ev;
        et = '0;
        eu = '0;
        for (int i = 0; i < N; i++) et[32*i +: 32] = m_times[i];
        for (int i = 0; i <= N; i++) eu[24*i +: 24] = m_units[i];
        ev = '0;
        if (int'(sel_index) <= N) ev = m_units[sel_index];
        check("ready", 128'(ready), 128'(m_ready));
        check("sel_err", 128'(sel_err), 128'(m_err));
        check("times_flat", times_flat, et);
        check("units_flat", 128'(units_flat), 128'(eu));
        check("sel_value", 128'(sel_value), 128'(ev));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_steps(input int n);
        sel_set = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input int idx, input logic [23:0] v);
        sel_set       = 1'b1;
        sel_index     = IW'(idx);
        sel_new_value = v;
        step();
        sel_set = 1'b0;
    endtask

    task automatic steps_to_ready(input int limit, output int n);
        n = 0;
        while (ready !== 1'b1 && n < limit) begin
            step();
            n++;
        end
    endtask

    function automatic logic [23:0] rand_bcd();
        logic [23:0] v = '0;
        for (int k = 0; k < 4; k++) v[4*k +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    initial begin
        int n;
        rst_n = 1'b0; ce = 1'b1; sel_set = 1'b0; sel_index = '0; sel_new_value = '0;

        // power-up defaults
        step();
        step();
        check("rst_times", times_flat, 128'd0);
        rst_n = 1'b1;
        steps_to_ready(200, n);
        check("lat_reset", 128'(n), 128'd112);
        idle_steps(120 - n);
        check("dit", 128'(times_flat[31:0]), 128'd50_000_000);
        check("dah", 128'(times_flat[63:32]), 128'd150_000_000);
        check("word", 128'(times_flat[95:64]), 128'd350_000_000);
        check("tol", 128'(times_flat[127:96]), 128'd25_000_000);

        // back-to-back writes restart once
        wr(0, 24'h000002);
        wr(4, 24'h000003);
        steps_to_ready(200, n);
        check("lat_write", 128'(n), 128'(LAT));
        check("dit_small", 128'(times_flat[31:0]), 128'd6);
        check("dah_small", 128'(times_flat[63:32]), 128'd9000);

        // rejected writes
        wr(1, 24'h00A000);
        check("err_nibble", 128'(sel_err), 128'd1);
        sel_index = 3'd1;
        idle_steps(1);
        check("val_kept", 128'(sel_value), 128'h003000);
        wr(7, 24'h000123);
        check("err_index", 128'(sel_err), 128'd1);
        idle_steps(1);
        check("err_pulse", 128'(sel_err), 128'd0);
        check("ready_kept", 128'(ready), 128'd1);

        // saturation
        wr(0, 24'h999999);
        wr(4, 24'h999999);
        steps_to_ready(200, n);
        check("dit_sat", 128'(times_flat[31:0]), 128'hFFFF_FFFF);
        check("dah_999", 128'(times_flat[63:32]), 128'd2_999_997_000);
        check("tol_999", 128'(times_flat[127:96]), 128'd499_999_500);

        // reset mid-pass
        wr(3, 24'h000500);
        idle_steps(50);
        rst_n = 1'b0;
        step();
        check("abort_times", times_flat, 128'd0);
        check("abort_ready", 128'(ready), 128'd0);
        rst_n = 1'b1;
        steps_to_ready(200, n);
        check("lat_rerun", 128'(n), 128'(LAT));
        check("dit_rerun", 128'(times_flat[31:0]), 128'd50_000_000);

        // clock-enable stall mid-pass
        wr(2, 24'h000700);
        idle_steps(20);
        ce = 1'b0;
        idle_steps(30);
        check("stall_ready", 128'(ready), 128'd0);
        ce = 1'b1;
        steps_to_ready(200, n);
        check("lat_stall", 128'(n + 50), 128'(LAT + 30));
        check("word_700", 128'(times_flat[95:64]), 128'd35_000_000);

        // randomized traffic, each round followed by a quiet pass
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 120; i++) begin
                rst_n         = ($urandom_range(0, 299) != 0);
                ce            = ($urandom_range(0, 7) != 0);
                sel_set       = ($urandom_range(0, 24) == 0);
                sel_index     = IW'($urandom_range(0, 7));
                sel_new_value = ($urandom_range(0, 3) == 0) ? 24'($urandom) : rand_bcd();
                step();
            end
            rst_n = 1'b1;
            ce    = 1'b1;
            idle_steps(LAT + 4);
            check("rand_ready", 128'(ready), 128'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
